// File: rtl/msgmii_pkg.sv
// ============================================================================
// Package : msgmii_pkg
// Brief   : Speed and state encodings for the SGMII receive rate controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package msgmii_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The reserved code 11 behaves as gigabit.
  function automatic logic [1:0] map_speed(input logic [1:0] cfg);
    return (cfg == 2'b11) ? SPD_1000 : cfg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msgmii_rx_rate_ctrl_if.sv
// ============================================================================
// Interface : msgmii_rx_rate_ctrl_if
// Brief     : PCS-side GMII input, converter-side output and status bundle.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface msgmii_rx_rate_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic [1:0]       speed_cfg;
  logic             speed_upd;
  logic [7:0]       rxd_in;
  logic             rx_dv_in;
  logic             rx_er_in;
  logic [1:0]       conv_speed;
  logic             conv_clr;
  logic [7:0]       rxd_out;
  logic             rx_dv_out;
  logic             rx_er_out;
  logic             smp_vld;
  logic             chg_busy;
  logic             align_err;
  logic [CNT_W-1:0] frm_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport slave (
    input  speed_cfg, speed_upd, rxd_in, rx_dv_in, rx_er_in,
    output conv_speed, conv_clr, rxd_out, rx_dv_out, rx_er_out,
           smp_vld, chg_busy, align_err, frm_cnt, err_cnt
  );

  modport master (
    output speed_cfg, speed_upd, rxd_in, rx_dv_in, rx_er_in,
    input  conv_speed, conv_clr, rxd_out, rx_dv_out, rx_er_out,
           smp_vld, chg_busy, align_err, frm_cnt, err_cnt
  );

endinterface

`default_nettype wire

// File: rtl/msgmii_rx_decim.sv
// ============================================================================
// Module : msgmii_rx_decim
// Brief  : Frame-aligned phase counter, mid-symbol sampler and alignment check.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module msgmii_rx_decim #(
  parameter bit ERR_EN = 1'b1
) (
  input  wire        clk,
  input  wire        rst_n,
  input  wire  [7:0] i_rep,
  input  wire        i_hold,
  input  wire  [7:0] i_rxd,
  input  wire        i_dv,
  input  wire        i_er,
  output logic [7:0] o_rxd,
  output logic       o_dv,
  output logic       o_er,
  output logic       o_smp,
  output logic       o_align_err
);

  logic       r_dv_d;
  logic [7:0] r_phase;
  logic       r_drop;
  logic [7:0] r_rxd;
  logic       r_dv;
  logic       r_er;
  logic       r_smp;
  logic       w_rise;
  logic       w_samp;
  logic [7:0] w_ph;

  // The rising-edge cycle is phase 0 even though the counter still holds the old value.
  assign w_rise = i_dv & ~r_dv_d;
  assign w_ph   = w_rise ? 8'd0 : r_phase;
  assign w_samp = ~i_hold & ~r_drop & (w_ph == {1'b0, i_rep[7:1]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dv_d  <= 1'b0;
      r_phase <= 8'd0;
      r_drop  <= 1'b0;
      r_rxd   <= 8'd0;
      r_dv    <= 1'b0;
      r_er    <= 1'b0;
      r_smp   <= 1'b0;
    end else begin
      r_dv_d <= i_dv;
      if (i_hold || (i_rep == 8'd1))
        r_phase <= 8'd0;
      else if (w_rise)
        r_phase <= 8'd1;
      else if (r_phase >= i_rep - 8'd1)
        r_phase <= 8'd0;
      else
        r_phase <= r_phase + 8'd1;
      // A frame that starts while held has no valid phase reference; drop it whole.
      if (i_hold)
        r_drop <= i_dv;
      else if (!i_dv)
        r_drop <= 1'b0;
      r_smp <= w_samp;
      if (i_hold) begin
        r_dv <= 1'b0;
        r_er <= 1'b0;
      end else if (w_samp) begin
        r_rxd <= i_rxd;
        r_dv  <= i_dv;
        r_er  <= i_er;
      end
    end
  end

  assign o_rxd = r_rxd;
  assign o_dv  = r_dv & ~i_hold;
  assign o_er  = r_er & ~i_hold;
  assign o_smp = r_smp & ~i_hold;

  generate
    if (ERR_EN) begin : g_align
      logic r_align;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_align <= 1'b0;
        else
          r_align <= ~i_dv & r_dv_d & (r_phase != 8'd0) & (i_rep != 8'd1)
                     & ~i_hold & ~r_drop;
      end
      assign o_align_err = r_align;
    end else begin : g_no_align
      assign o_align_err = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/msgmii_rx_rate_ctrl.sv
// ============================================================================
// Module : msgmii_rx_rate_ctrl
// Brief  : SGMII RX decimation with frame-safe speed switching; stats via
//          MSGMII_RX_RATE_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module msgmii_rx_rate_ctrl
  import msgmii_pkg::*;
#(
  parameter int REP10     = 100,
  parameter int REP100    = 10,
  parameter int DRAIN_CYC = 4,
  parameter int IDLE_MIN  = 12,
  parameter int CNT_W     = 16
) (
  input  wire                   clk,
  input  wire                   rst_n,
  msgmii_rx_rate_ctrl_if.slave  bus
);

  localparam logic [7:0] c_IDLE_MIN   = 8'(IDLE_MIN);
  localparam logic [3:0] c_DRAIN_LAST = 4'(DRAIN_CYC - 1);
`ifdef MSGMII_RX_RATE_STATS_EN
  localparam bit c_STATS_EN = 1'b1;
`else
  localparam bit c_STATS_EN = 1'b0;
`endif

  state_t     r_state, w_state_nxt;
  logic [1:0] r_req;
  logic [1:0] r_conv_speed, w_speed_nxt;
  logic       r_conv_clr, w_clr_nxt;
  logic [7:0] r_idle_cnt, w_idle_nxt;
  logic [3:0] r_drain_cnt, w_drain_nxt;
  logic [7:0] w_rep;
  logic       w_hold;
  logic       w_align_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_req <= SPD_1000;
    else if (bus.speed_upd)
      r_req <= map_speed(bus.speed_cfg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_conv_speed <= SPD_1000;
      r_conv_clr   <= 1'b0;
      r_idle_cnt   <= 8'd0;
      r_drain_cnt  <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_conv_speed <= w_speed_nxt;
      r_conv_clr   <= w_clr_nxt;
      r_idle_cnt   <= w_idle_nxt;
      r_drain_cnt  <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_conv_speed;
    w_clr_nxt   = 1'b0;
    w_idle_nxt  = r_idle_cnt;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      ST_IDLE: begin
        w_idle_nxt  = 8'd0;
        w_drain_nxt = 4'd0;
        if (r_req != r_conv_speed)
          w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (r_req == r_conv_speed) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.rx_dv_in) begin
          w_idle_nxt = 8'd0;
        end else if (r_idle_cnt + 8'd1 == c_IDLE_MIN) begin
          w_speed_nxt = r_req;
          w_clr_nxt   = 1'b1;
          w_idle_nxt  = 8'd0;
          w_drain_nxt = 4'd0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_idle_nxt = r_idle_cnt + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == c_DRAIN_LAST) begin
          w_drain_nxt = 4'd0;
          w_state_nxt = (r_req != r_conv_speed) ? ST_PEND : ST_IDLE;
        end else begin
          w_drain_nxt = r_drain_cnt + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_hold = (r_state == ST_DRAIN);

  always_comb begin
    case (r_conv_speed)
      SPD_10:  w_rep = 8'(REP10);
      SPD_100: w_rep = 8'(REP100);
      default: w_rep = 8'd1;
    endcase
  end

  msgmii_rx_decim #(
    .ERR_EN (c_STATS_EN)
  ) u_decim (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rep       (w_rep),
    .i_hold      (w_hold),
    .i_rxd       (bus.rxd_in),
    .i_dv        (bus.rx_dv_in),
    .i_er        (bus.rx_er_in),
    .o_rxd       (bus.rxd_out),
    .o_dv        (bus.rx_dv_out),
    .o_er        (bus.rx_er_out),
    .o_smp       (bus.smp_vld),
    .o_align_err (w_align_err)
  );

  assign bus.conv_speed = r_conv_speed;
  assign bus.conv_clr   = r_conv_clr;
  assign bus.chg_busy   = (r_state != ST_IDLE);
  assign bus.align_err  = w_align_err;

`ifdef MSGMII_RX_RATE_STATS_EN
  logic             r_frm_dv_d;
  logic [CNT_W-1:0] r_frm_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm_dv_d <= 1'b0;
      r_frm_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_frm_dv_d <= bus.rx_dv_in;
      if (bus.rx_dv_in && !r_frm_dv_d && !(&r_frm_cnt))
        r_frm_cnt <= r_frm_cnt + 1'b1;
      if (w_align_err && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.frm_cnt = r_frm_cnt;
  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.frm_cnt = {CNT_W{1'b0}};
  assign bus.err_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: doc/msgmii_rx_rate_ctrl.md
Name: msgmii_rx_rate_ctrl

Overview:
- Rate controller placed in front of the SGMII receive nibble/byte converter.
- At 10/100 Mb/s, SGMII replicates each GMII symbol 100/10 times on the 125 MHz receive clock. This block decimates the stream to one sample per symbol, phase-aligned to frame start.
- It applies speed changes to the converter only at frame-safe points, with a drain/clear sequence.
- It flags replication-boundary violations.

Parameters:
- REP10, 100, replication factor at 10 Mb/s (2..255).
- REP100, 10, replication factor at 100 Mb/s (2..255).
- DRAIN_CYC, 4, cycles converter input is held idle after a speed change (1..15).
- IDLE_MIN, 12, minimum rx_dv_in-low cycles before a pending speed change is applied (1..255).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  receive clock, 125 MHz.
- rst_n  in  1  asynchronous active-low reset.
- speed_cfg  in  2  requested speed: 00=10M, 01=100M, 10=1000M, 11 treated as 1000M.
- speed_upd  in  1  one-cycle pulse: sample speed_cfg as the new request.
- rxd_in  in  8  GMII data from PCS, replicated.
- rx_dv_in  in  1  GMII data valid from PCS.
- rx_er_in  in  1  GMII error from PCS.
- conv_speed  out  2  speed applied to the converter.
- conv_clr  out  1  one-cycle synchronous clear to the converter.
- rxd_out  out  8  decimated data to the converter.
- rx_dv_out  out  1  decimated valid.
- rx_er_out  out  1  decimated error.
- smp_vld  out  1  one-cycle strobe: rxd_out/rx_dv_out/rx_er_out updated this cycle.
- chg_busy  out  1  speed change pending or draining.
- align_err  out  1  one-cycle pulse on a replication-boundary violation.
- frm_cnt  out  CNT_W  frames seen (saturating).
- err_cnt  out  CNT_W  alignment errors (saturating).

Behaviour:
- Reset: conv_speed=10 (1000M); all other outputs 0; state IDLE; req_speed=10; phase=0.
- Registered request:
  - speed_upd loads req_speed from speed_cfg (11 is mapped to 10).
  - A new speed_upd during PEND or DRAIN overwrites req_speed.
  - During DRAIN, that new request takes effect only after DRAIN completes, via a new PEND.
- Replication factor: R = REP10 / REP100 / 1, selected from conv_speed, never from req_speed.
- Phase counter (8 bit):
  - Rising edge of rx_dv_in loads phase=1.
  - Otherwise phase increments and wraps to 0 after R-1.
  - In 1000M mode phase is held at 0.
- Sample point:
  - In 10/100 mode the sample is taken when phase == R/2 (integer divide). The rising-edge cycle counts as phase 0.
  - In 1000M mode every cycle is a sample.
  - On a sample cycle, outputs register the inputs and smp_vld=1. Latency is 1 clk from the input cycle.
  - Outside sample cycles, outputs hold and smp_vld=0.
- Alignment error (10/100 only): rx_dv_in falling while phase != 0 -> align_err=1 for one cycle and err_cnt+1. Phase then restarts at the next rising edge.
- frm_cnt increments on each rx_dv_in rising edge.
- Both counters saturate at all-ones.
- States:
  - IDLE: no change pending. req_speed != conv_speed -> PEND (also entered when the request arrives while rx_dv_in is high).
  - PEND: chg_busy=1. Idle-run counter counts consecutive rx_dv_in=0 cycles; it resets whenever rx_dv_in=1. When count reaches IDLE_MIN: conv_speed<=req_speed, conv_clr=1 for that single cycle, then -> DRAIN.
  - DRAIN: chg_busy=1. rx_dv_out/rx_er_out forced 0, smp_vld forced 0 for DRAIN_CYC cycles. Phase is held at 0. Then -> IDLE, or -> PEND if req_speed != conv_speed.
- A request equal to conv_speed while in PEND cancels the change: return to IDLE, no conv_clr.
- An rx_dv_in rising edge during DRAIN is ignored for sampling; the frame is dropped. frm_cnt still counts it.
- Reset mid-change abandons it: conv_speed returns to 1000M.

Optional Feature:
- Macro MSGMII_RX_RATE_STATS_EN.
- Defined: frm_cnt, err_cnt and the align_err pulse are implemented as above.
- Undefined: frm_cnt=0, err_cnt=0 and align_err=0 (tied off); no counter flops; decimation and speed sequencing are unchanged.

Decomposition:
- Shared package msgmii_pkg holds:
  - speed encodings SPD_10=2'b00, SPD_100=2'b01, SPD_1000=2'b10;
  - state encodings ST_IDLE, ST_PEND, ST_DRAIN.
- One natural sub-module: msgmii_rx_decim. It contains the phase counter, sample-point compare, output sample registers and align_err detect. Inputs: R, rx_* and a hold signal.
- FSM and counters stay in the top module.

Test Plan:
- Reset, 1000M, frame of 64 cycles rx_dv_in=1 with rxd_in counting 0..63 -> smp_vld every cycle, rxd_out = input delayed 1 clk, frm_cnt=1.
- speed_upd with speed_cfg=01 while idle -> chg_busy for 12 + 4 cycles; conv_clr single pulse at cycle 12; conv_speed=01; no smp_vld during drain.
- 100M, frame of 8 symbols each replicated 10x (values A0..A7) -> exactly 8 smp_vld pulses, each at cycle 5 of its symbol, rxd_out=A0..A7, align_err never set.
- 10M, rx_dv_in dropped after 150 cycles (phase 50) -> align_err pulse, err_cnt=1. Next aligned frame samples correctly.
- speed_upd to 10M mid-frame at 100M -> conv_speed unchanged until 12 idle cycles after frame end. A second speed_upd back to 01 during PEND -> back to IDLE, no conv_clr.
- Assert rst_n=0 during DRAIN -> all outputs 0 and conv_speed=10 immediately (asynchronous). After release, a frame at 1000M passes.
